// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instr/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned WORD_WIDTH = 32;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } arb_owner_e;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_owner_fifo.sv
// Records which master issued each outstanding memory request, oldest at head.
module arb_owner_fifo
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  arb_owner_e owner_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output arb_owner_e head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  arb_owner_e       store_q [DEPTH];
  arb_owner_e       store_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = store_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    store_d  = store_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      store_d[wr_ptr_q] = owner_i;
      wr_ptr_d          = next_ptr(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      store_q  <= '{default: OWNER_INSTR};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      store_q  <= store_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instr and data masters: data priority with
// instr anti-starvation, request locking until grant, in-order response routing.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  instr_req_i,
  input  logic [WORD_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [WORD_WIDTH-1:0] instr_rdata_o,
  input  logic                  data_req_i,
  input  logic [WORD_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [WORD_WIDTH-1:0] data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [WORD_WIDTH-1:0] data_rdata_o,
  output logic                  mem_req_o,
  output logic [WORD_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [WORD_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [WORD_WIDTH-1:0] mem_rdata_i,
  output logic                  arb_err_o
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                err_q, err_d;
  logic                sel_instr, winner_req, push, pop;
  logic                fifo_full, fifo_empty;
  arb_owner_e          head_owner;

  // A locked master keeps the port; otherwise data wins unless instr has starved.
  always_comb begin
    sel_instr = 1'b0;
    case (state_q)
      LOCK_I:  sel_instr = 1'b1;
      LOCK_D:  sel_instr = 1'b0;
      default: begin
        if (instr_req_i && data_req_i) sel_instr = (starve_q == STARVE_W'(STARVE_LIMIT));
        else                           sel_instr = instr_req_i;
      end
    endcase
  end

  assign winner_req  = sel_instr ? instr_req_i : data_req_i;
  assign mem_req_o   = winner_req && !fifo_full && !rst_i;
  assign mem_addr_o  = sel_instr ? instr_addr_i : data_addr_i;
  assign mem_we_o    = sel_instr ? 1'b0 : data_we_i;
  assign mem_be_o    = sel_instr ? 4'hF : data_be_i;
  assign mem_wdata_o = sel_instr ? '0 : data_wdata_i;

  assign push        = mem_req_o && mem_gnt_i;
  assign instr_gnt_o = push && sel_instr;
  assign data_gnt_o  = push && !sel_instr;

  assign pop            = mem_rvalid_i && !fifo_empty && !rst_i;
  assign instr_rvalid_o = pop && (head_owner == OWNER_INSTR);
  assign data_rvalid_o  = pop && (head_owner == OWNER_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign arb_err_o      = err_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB: begin
        if (mem_req_o && !mem_gnt_i) state_d = sel_instr ? LOCK_I : LOCK_D;
      end
      LOCK_I, LOCK_D: begin
        if (mem_gnt_i) state_d = ARB;
      end
      default: state_d = ARB;
    endcase

    starve_d = starve_q;
    if (!instr_req_i || instr_gnt_o) begin
      starve_d = '0;
    end else if (data_gnt_o && (starve_q != STARVE_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + 1'b1;
    end

    err_d = err_q || (mem_rvalid_i && fifo_empty);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ARB;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  arb_owner_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push),
    .owner_i(sel_instr ? OWNER_INSTR : OWNER_DATA),
    .pop_i  (pop),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (head_owner)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus
// hand-written lock, starvation and reset sequences.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam logic [31:0] IADDR  = 32'h0000_0040;
  localparam logic [31:0] DADDR  = 32'h0000_0100;
  localparam logic [3:0]  DBE    = 4'h3;
  localparam logic [31:0] DWDATA = 32'h0000_0055;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req, data_req, mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        instr_gnt, instr_rvalid, data_gnt, data_rvalid;
  logic [31:0] instr_rdata, data_rdata, mem_addr, mem_wdata;
  logic        mem_req, mem_we, arb_err;
  logic [3:0]  mem_be;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .MAX_OUTSTANDING(2),
    .STARVE_LIMIT   (4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .instr_req_i   (instr_req),
    .instr_addr_i  (IADDR),
    .instr_gnt_o   (instr_gnt),
    .instr_rvalid_o(instr_rvalid),
    .instr_rdata_o (instr_rdata),
    .data_req_i    (data_req),
    .data_addr_i   (DADDR),
    .data_we_i     (1'b1),
    .data_be_i     (DBE),
    .data_wdata_i  (DWDATA),
    .data_gnt_o    (data_gnt),
    .data_rvalid_o (data_rvalid),
    .data_rdata_o  (data_rdata),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .mem_we_o      (mem_we),
    .mem_be_o      (mem_be),
    .mem_wdata_o   (mem_wdata),
    .mem_gnt_i     (mem_gnt),
    .mem_rvalid_i  (mem_rvalid),
    .mem_rdata_i   (mem_rdata),
    .arb_err_o     (arb_err)
  );

  typedef struct {
    logic        ireq;
    logic        dreq;
    logic        mgnt;
    logic        mrv;
    logic [31:0] mrdata;
    logic        eIgnt;
    logic        eDgnt;
    logic        eMreq;
    logic        eSelI;
    logic        eIrv;
    logic        eDrv;
    logic        eErr;
  } vec_t;

  vec_t vecs [13];
  logic expI [10];

  task automatic applyStimulus(input logic ireq, input logic dreq, input logic mgnt,
                               input logic mrv, input logic [31:0] mrdata);
    instr_req  = ireq;
    data_req   = dreq;
    mem_gnt    = mgnt;
    mem_rvalid = mrv;
    mem_rdata  = mrdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Checks the mem_* fields against the selected master's constant request fields.
  task automatic checkMux(input string name, input logic selInstr);
    checkOutput({name, " mem_addr"},  mem_addr,        selInstr ? IADDR : DADDR);
    checkOutput({name, " mem_we"},    32'(mem_we),     selInstr ? 32'd0 : 32'd1);
    checkOutput({name, " mem_be"},    32'(mem_be),     selInstr ? 32'hF : 32'(DBE));
    checkOutput({name, " mem_wdata"}, mem_wdata,       selInstr ? 32'd0 : DWDATA);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ireq, dreq, mgnt, mrv, mrdata, eIgnt, eDgnt, eMreq, eSelI, eIrv, eDrv, eErr
    vecs[0]  = '{1, 0, 1, 0, 32'h0,         1, 0, 1, 1, 0, 0, 0};
    vecs[1]  = '{0, 0, 1, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 1, 0, 0};
    vecs[2]  = '{1, 0, 1, 0, 32'h0,         1, 0, 1, 1, 0, 0, 0};
    vecs[3]  = '{0, 1, 1, 0, 32'h0,         0, 1, 1, 0, 0, 0, 0};
    vecs[4]  = '{1, 1, 1, 0, 32'h0,         0, 0, 0, 0, 0, 0, 0};
    vecs[5]  = '{1, 1, 1, 1, 32'h1111_1111, 0, 0, 0, 0, 1, 0, 0};
    vecs[6]  = '{1, 1, 1, 1, 32'h2222_2222, 0, 1, 1, 0, 0, 1, 0};
    vecs[7]  = '{1, 0, 1, 1, 32'h3333_3333, 1, 0, 1, 1, 0, 1, 0};
    vecs[8]  = '{0, 0, 0, 1, 32'h4444_4444, 0, 0, 0, 0, 1, 0, 0};
    vecs[9]  = '{0, 0, 0, 1, 32'h5555_5555, 0, 0, 0, 0, 0, 0, 0};
    vecs[10] = '{0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 0, 1};
    vecs[11] = '{1, 0, 1, 0, 32'h0,         1, 0, 1, 1, 0, 0, 1};
    vecs[12] = '{0, 0, 0, 1, 32'h6666_6666, 0, 0, 0, 0, 1, 0, 1};
    expI = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    // Reset with every request active: all handshake outputs must stay low.
    rst = 1'b1;
    applyStimulus(1, 1, 1, 1, 32'h0);
    #3;
    checkOutput("rst mem_req", 32'(mem_req), 0);
    checkOutput("rst instr_gnt", 32'(instr_gnt), 0);
    checkOutput("rst data_gnt", 32'(data_gnt), 0);
    checkOutput("rst instr_rvalid", 32'(instr_rvalid), 0);
    checkOutput("rst data_rvalid", 32'(data_rvalid), 0);
    checkOutput("rst arb_err", 32'(arb_err), 0);
    nextCycle();
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].ireq, vecs[i].dreq, vecs[i].mgnt, vecs[i].mrv, vecs[i].mrdata);
      #3;
      checkOutput($sformatf("v%0d instr_gnt", i), 32'(instr_gnt), 32'(vecs[i].eIgnt));
      checkOutput($sformatf("v%0d data_gnt", i), 32'(data_gnt), 32'(vecs[i].eDgnt));
      checkOutput($sformatf("v%0d mem_req", i), 32'(mem_req), 32'(vecs[i].eMreq));
      checkMux($sformatf("v%0d", i), vecs[i].eSelI);
      checkOutput($sformatf("v%0d instr_rvalid", i), 32'(instr_rvalid), 32'(vecs[i].eIrv));
      checkOutput($sformatf("v%0d data_rvalid", i), 32'(data_rvalid), 32'(vecs[i].eDrv));
      checkOutput($sformatf("v%0d arb_err", i), 32'(arb_err), 32'(vecs[i].eErr));
      if (vecs[i].eIrv) checkOutput($sformatf("v%0d instr_rdata", i), instr_rdata, vecs[i].mrdata);
      if (vecs[i].eDrv) checkOutput($sformatf("v%0d data_rdata", i), data_rdata, vecs[i].mrdata);
      nextCycle();
    end

    // Reset with two outstanding requests; stale entries must be discarded.
    applyStimulus(1, 0, 1, 0, 32'h0);
    #3;
    checkOutput("rs6 pre instr_gnt", 32'(instr_gnt), 1);
    nextCycle();
    applyStimulus(0, 1, 1, 0, 32'h0);
    #3;
    checkOutput("rs6 pre data_gnt", 32'(data_gnt), 1);
    nextCycle();
    applyStimulus(1, 1, 1, 1, 32'h0);
    rst = 1'b1;
    #1;
    checkOutput("rs6 mem_req", 32'(mem_req), 0);
    checkOutput("rs6 gnt", {30'd0, instr_gnt, data_gnt}, 0);
    checkOutput("rs6 rvalid", {30'd0, instr_rvalid, data_rvalid}, 0);
    checkOutput("rs6 arb_err", 32'(arb_err), 0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1, 0, 1, 0, 32'h0);
    #3;
    checkOutput("rs6 post mem_req", 32'(mem_req), 1);
    checkOutput("rs6 post instr_gnt", 32'(instr_gnt), 1);
    nextCycle();
    applyStimulus(0, 0, 0, 1, 32'h7777_7777);
    #3;
    checkOutput("rs6 post instr_rvalid", 32'(instr_rvalid), 1);
    checkOutput("rs6 post data_rvalid", 32'(data_rvalid), 0);
    checkOutput("rs6 post arb_err", 32'(arb_err), 0);
    nextCycle();
    applyStimulus(0, 0, 0, 1, 32'h8888_8888);
    #3;
    checkOutput("rs6 late instr_rvalid", 32'(instr_rvalid), 0);
    checkOutput("rs6 late data_rvalid", 32'(data_rvalid), 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 32'h0);
    #3;
    checkOutput("rs6 late arb_err", 32'(arb_err), 1);
    nextCycle();

    // Both masters requesting continuously: instr forced in after four data grants.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(i < 10, i < 10, 1, i > 0, 32'(i));
      #3;
      if (i < 10) begin
        checkOutput($sformatf("starve%0d instr_gnt", i), 32'(instr_gnt), 32'(expI[i]));
        checkOutput($sformatf("starve%0d data_gnt", i), 32'(data_gnt), 32'(!expI[i]));
      end
      if (i > 0) begin
        checkOutput($sformatf("starve%0d instr_rvalid", i), 32'(instr_rvalid), 32'(expI[i-1]));
        checkOutput($sformatf("starve%0d data_rvalid", i), 32'(data_rvalid), 32'(!expI[i-1]));
      end
      nextCycle();
    end

    // Data held off by mem_gnt low for three cycles stays locked on the port.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i > 0, 1, i == 3, 0, 32'h0);
      #3;
      checkOutput($sformatf("lockD%0d mem_req", i), 32'(mem_req), 1);
      checkMux($sformatf("lockD%0d", i), 1'b0);
      checkOutput($sformatf("lockD%0d data_gnt", i), 32'(data_gnt), 32'(i == 3));
      checkOutput($sformatf("lockD%0d instr_gnt", i), 32'(instr_gnt), 0);
      nextCycle();
    end
    applyStimulus(1, 0, 1, 0, 32'h0);
    #3;
    checkOutput("lockD instr_gnt after", 32'(instr_gnt), 1);
    checkMux("lockD after", 1'b1);
    nextCycle();
    applyStimulus(0, 0, 0, 1, 32'hAAAA_0001);
    #3;
    checkOutput("lockD rsp1 data_rvalid", 32'(data_rvalid), 1);
    checkOutput("lockD rsp1 data_rdata", data_rdata, 32'hAAAA_0001);
    nextCycle();
    applyStimulus(0, 0, 0, 1, 32'hAAAA_0002);
    #3;
    checkOutput("lockD rsp2 instr_rvalid", 32'(instr_rvalid), 1);
    checkOutput("lockD rsp2 instr_rdata", instr_rdata, 32'hAAAA_0002);
    nextCycle();

    // Instr waiting on mem_gnt keeps the port even when data, the priority master, arrives.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, i > 0, i == 2, 0, 32'h0);
      #3;
      checkMux($sformatf("lockI%0d", i), 1'b1);
      checkOutput($sformatf("lockI%0d instr_gnt", i), 32'(instr_gnt), 32'(i == 2));
      checkOutput($sformatf("lockI%0d data_gnt", i), 32'(data_gnt), 0);
      nextCycle();
    end
    applyStimulus(0, 1, 1, 0, 32'h0);
    #3;
    checkOutput("lockI data_gnt after", 32'(data_gnt), 1);
    checkMux("lockI after", 1'b0);
    nextCycle();
    applyStimulus(0, 0, 0, 1, 32'hBBBB_0001);
    #3;
    checkOutput("lockI rsp1 instr_rvalid", 32'(instr_rvalid), 1);
    nextCycle();
    applyStimulus(0, 0, 0, 1, 32'hBBBB_0002);
    #3;
    checkOutput("lockI rsp2 data_rvalid", 32'(data_rvalid), 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 32'h0);
    nextCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
